bcd_score_keeper: RTL and testbench

BCD_SCORE_KEEPER -- requirements
Module: bcd_score_keeper

---
 rtl/score_pkg.sv | 19 +
 rtl/bcd_digit_addsub.sv | 42 ++++
 rtl/bcd_score_keeper.sv | 158 +++++++++++++++
 tb/tb_bcd_score_keeper.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared BCD types and constants for the score keeper and its digit slice.
package score_pkg;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } op_e;

  // Award amounts above a single decimal digit are clipped to 9.
  function automatic bcd_digit_t clamp_step(input logic [3:0] s);
    return (s > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : s;
  endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// One decimal digit of a ripple BCD adder/subtractor; cin/cout carry either
// the decimal carry (add) or the decimal borrow (subtract).
module bcd_digit_addsub
  import score_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  bcd_digit_t operand_i,
  input  logic       sub_i,
  input  logic       cin_i,
  output bcd_digit_t digit_o,
  output logic       cout_o
);

  logic [4:0] sum;
  logic [4:0] sum_adj;
  logic [4:0] diff;

  always_comb begin
    sum     = {1'b0, digit_i} + {1'b0, operand_i} + {4'd0, cin_i};
    sum_adj = sum - 5'd10;
    diff    = {1'b0, digit_i} - {1'b0, operand_i} - {4'd0, cin_i};
    digit_o = digit_i;
    cout_o  = 1'b0;
    if (sub_i) begin
      // A negative difference wraps modulo 16; adding 10 restores the decimal digit.
      if (diff[4]) begin
        digit_o = diff[3:0] + 4'd10;
        cout_o  = 1'b1;
      end else begin
        digit_o = diff[3:0];
      end
    end else begin
      if (sum > 5'd9) begin
        digit_o = sum_adj[3:0];
        cout_o  = 1'b1;
      end else begin
        digit_o = sum[3:0];
      end
    end
  end

endmodule

// File: rtl/bcd_score_keeper.sv
// Packed-BCD score counter driven by asynchronous right/wrong strobes, with
// saturation, per-game best tracking and a score-changed pulse.
module bcd_score_keeper
  import score_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  right,
  input  logic                  wrong,
  input  logic [3:0]            step,
  input  logic                  new_game,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   best,
  output logic                  saturated,
  output logic                  changed
);

  localparam int W        = 4 * DIGITS;
  localparam int CH_RIGHT = 0;
  localparam int CH_WRONG = 1;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{BCD_MAX_DIGIT}};

  logic [1:0] raw_in;
  logic [1:0] evt;

  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   fill_done;

  logic [W-1:0] score_q, score_d;
  logic [W-1:0] best_q, best_d;
  logic         saturated_q, saturated_d;
  logic         changed_q, changed_d;

  assign raw_in = {wrong, right};

  // Marks when the synchronizers hold real input samples rather than reset zeros.
  always_comb fill_d = {fill_q[SYNC_STAGES-2:0], 1'b1};
  assign fill_done = fill_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fill_q <= '0;
    else        fill_q <= fill_d;
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic                   arm_q, arm_d;

    // A channel only arms after seeing its input low, so a level already high
    // at reset release never counts as an edge.
    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], raw_in[gi]};
      edge_d = sync_q[SYNC_STAGES-1];
      arm_d  = arm_q | (fill_done & ~sync_q[SYNC_STAGES-1]);
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        sync_q <= '0;
        edge_q <= 1'b0;
        arm_q  <= 1'b0;
      end else begin
        sync_q <= sync_d;
        edge_q <= edge_d;
        arm_q  <= arm_d;
      end
    end

    assign evt[gi] = sync_q[SYNC_STAGES-1] & ~edge_q & arm_q;
  end

  op_e op;

  always_comb begin
    op = OP_NONE;
    if (!new_game) begin
      if (evt[CH_RIGHT] && !evt[CH_WRONG])      op = OP_ADD;
      else if (evt[CH_WRONG] && !evt[CH_RIGHT]) op = OP_SUB;
    end
  end

  logic              sub_mode;
  bcd_digit_t        lsd_operand;
  logic [DIGITS:0]   carry;
  logic [W-1:0]      chain_result;

  assign sub_mode    = (op == OP_SUB);
  assign lsd_operand = sub_mode ? 4'd1 : clamp_step(step);
  assign carry[0]    = 1'b0;

  for (gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit_t operand;
    assign operand = (gi == 0) ? lsd_operand : 4'd0;

    bcd_digit_addsub u_digit (
      .digit_i   (score_q[4*gi +: 4]),
      .operand_i (operand),
      .sub_i     (sub_mode),
      .cin_i     (carry[gi]),
      .digit_o   (chain_result[4*gi +: 4]),
      .cout_o    (carry[gi+1])
    );
  end

  // Carry out of the top digit means overflow (add) or a decrement below zero (sub).
  always_comb begin
    score_d     = score_q;
    best_d      = best_q;
    saturated_d = saturated_q;
    if (new_game) begin
      best_d      = (score_q > best_q) ? score_q : best_q;
      score_d     = '0;
      saturated_d = 1'b0;
    end else begin
      case (op)
        OP_ADD: begin
          if (carry[DIGITS]) begin
            score_d     = ALL_NINES;
            saturated_d = 1'b1;
          end else begin
            score_d = chain_result;
          end
        end
        OP_SUB: begin
          if (!carry[DIGITS]) score_d = chain_result;
        end
        default: ;
      endcase
    end
  end

  assign changed_d = (score_d != score_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      score_q     <= '0;
      best_q      <= '0;
      saturated_q <= 1'b0;
      changed_q   <= 1'b0;
    end else begin
      score_q     <= score_d;
      best_q      <= best_d;
      saturated_q <= saturated_d;
      changed_q   <= changed_d;
    end
  end

  assign score     = score_q;
  assign best      = best_q;
  assign saturated = saturated_q;
  assign changed   = changed_q;

endmodule

// File: tb/tb_bcd_score_keeper.sv
// Directed and randomized checks of bcd_score_keeper against an integer-arithmetic model.
module tb_bcd_score_keeper;

  localparam int DIGITS      = 2;
  localparam int SYNC_STAGES = 2;
  localparam int W           = 4 * DIGITS;
  localparam int MAXV        = (10 ** DIGITS) - 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         right = 1'b0;
  logic         wrong = 1'b0;
  logic [3:0]   step  = 4'd0;
  logic         new_game = 1'b0;
  logic [W-1:0] score;
  logic [W-1:0] best;
  logic         saturated;
  logic         changed;

  bcd_score_keeper #(.DIGITS(DIGITS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clock     (clock),
    .reset     (reset),
    .right     (right),
    .wrong     (wrong),
    .step      (step),
    .new_game  (new_game),
    .score     (score),
    .best      (best),
    .saturated (saturated),
    .changed   (changed)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_mis = 0;
  int pulse_cnt = 0;

  // Reference model: integer score, rises delayed by the synchronizer latency.
  int m_score, m_best;
  bit m_sat, m_chg;
  bit pend_r [SYNC_STAGES];
  bit pend_w [SYNC_STAGES];
  bit prev_r, prev_w;
  bit ev_r, ev_w;
  int old_score, st;

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_score = 0; m_best = 0; m_sat = 0; m_chg = 0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        pend_r[i] = 0;
        pend_w[i] = 0;
      end
      prev_r = right;
      prev_w = wrong;
    end else begin
      ev_r = pend_r[SYNC_STAGES-1];
      ev_w = pend_w[SYNC_STAGES-1];
      for (int i = SYNC_STAGES-1; i > 0; i--) begin
        pend_r[i] = pend_r[i-1];
        pend_w[i] = pend_w[i-1];
      end
      pend_r[0] = right & ~prev_r;
      pend_w[0] = wrong & ~prev_w;
      prev_r = right;
      prev_w = wrong;
      old_score = m_score;
      if (new_game) begin
        if (m_score > m_best) m_best = m_score;
        m_score = 0;
        m_sat = 0;
      end else if (ev_r && !ev_w) begin
        st = (step > 4'd9) ? 9 : int'(step);
        if (m_score + st > MAXV) begin
          m_score = MAXV;
          m_sat = 1;
        end else begin
          m_score = m_score + st;
        end
      end else if (ev_w && !ev_r) begin
        if (m_score > 0) m_score = m_score - 1;
      end
      m_chg = (m_score != old_score);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    chk("score", 32'(score), 32'(int2bcd(m_score)));
    chk("best", 32'(best), 32'(int2bcd(m_best)));
    chk("saturated", 32'(saturated), 32'(m_sat));
    chk("changed", 32'(changed), 32'(m_chg));
    if (changed) pulse_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rst_assert();
    reset = 1'b0;
    #1;
    chk("rst_score", 32'(score), 32'h0);
    chk("rst_best", 32'(best), 32'h0);
    chk("rst_sat", 32'(saturated), 32'h0);
    chk("rst_changed", 32'(changed), 32'h0);
  endtask

  task automatic rst_release();
    reset = 1'b1;
    idle(4);
  endtask

  task automatic award(input logic [3:0] s);
    step = s;
    right = 1'b1;
    idle(2);
    right = 1'b0;
    idle(3);
  endtask

  task automatic penalize();
    wrong = 1'b1;
    idle(2);
    wrong = 1'b0;
    idle(3);
  endtask

  task automatic end_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    tick();
  endtask

  int p0;

  initial begin
    #2;
    rst_assert();
    idle(2);
    rst_release();

    // Ten single-step awards
    p0 = pulse_cnt;
    for (int i = 0; i < 10; i++) award(4'd1);
    chk("r32_score", 32'(score), 32'h10);
    chk("r32_pulses", 32'(pulse_cnt - p0), 32'd10);
    chk("r32_best", 32'(best), 32'h00);

    // Saturation at all-nines
    end_game();
    for (int i = 0; i < 10; i++) award(4'd9);
    award(4'd5);
    chk("r33_pre", 32'(score), 32'h95);
    award(4'd7);
    chk("r33_sat_score", 32'(score), 32'h99);
    chk("r33_sat_flag", 32'(saturated), 32'h1);
    p0 = pulse_cnt;
    award(4'd7);
    chk("r33_hold_score", 32'(score), 32'h99);
    chk("r33_hold_pulses", 32'(pulse_cnt - p0), 32'd0);
    chk("r33_hold_flag", 32'(saturated), 32'h1);

    // Decrement at zero and with borrow
    end_game();
    p0 = pulse_cnt;
    penalize();
    chk("r34_zero_score", 32'(score), 32'h00);
    chk("r34_zero_pulses", 32'(pulse_cnt - p0), 32'd0);
    award(4'd9);
    award(4'd1);
    penalize();
    chk("r34_borrow", 32'(score), 32'h09);

    // Best tracking across games
    rst_assert();
    idle(1);
    rst_release();
    for (int i = 0; i < 3; i++) award(4'd9);
    award(4'd3);
    end_game();
    chk("r35_best30", 32'(best), 32'h30);
    for (int i = 0; i < 4; i++) award(4'd9);
    award(4'd6);
    chk("r35_pre42", 32'(score), 32'h42);
    end_game();
    chk("r35_best42", 32'(best), 32'h42);
    chk("r35_score0", 32'(score), 32'h00);
    chk("r35_sat0", 32'(saturated), 32'h0);
    award(4'd9);
    award(4'd9);
    award(4'd2);
    end_game();
    chk("r35_keep42", 32'(best), 32'h42);

    // Held level and simultaneous edges
    p0 = pulse_cnt;
    step = 4'd1;
    right = 1'b1;
    idle(20);
    right = 1'b0;
    idle(4);
    chk("r36_held_score", 32'(score), 32'h01);
    chk("r36_held_pulses", 32'(pulse_cnt - p0), 32'd1);
    p0 = pulse_cnt;
    step = 4'd5;
    right = 1'b1;
    wrong = 1'b1;
    idle(3);
    right = 1'b0;
    wrong = 1'b0;
    idle(4);
    chk("r36_cancel_score", 32'(score), 32'h01);
    chk("r36_cancel_pulses", 32'(pulse_cnt - p0), 32'd0);

    // Reset interactions
    step = 4'd3;
    right = 1'b1;
    tick();
    rst_assert();
    idle(2);
    p0 = pulse_cnt;
    rst_release();
    idle(4);
    chk("r37_held_score", 32'(score), 32'h00);
    chk("r37_held_pulses", 32'(pulse_cnt - p0), 32'd0);
    right = 1'b0;
    idle(3);
    right = 1'b1;
    tick();
    rst_assert();
    right = 1'b0;
    idle(2);
    p0 = pulse_cnt;
    rst_release();
    idle(4);
    chk("r37_abort_score", 32'(score), 32'h00);
    chk("r37_abort_pulses", 32'(pulse_cnt - p0), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) right = ~right;
      if ($urandom_range(0, 5) == 0) wrong = ~wrong;
      step = 4'($urandom_range(0, 15));
      new_game = ($urandom_range(0, 29) == 0);
      tick();
    end
    right = 1'b0;
    wrong = 1'b0;
    new_game = 1'b0;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
